pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
- Sequencing controller for the next-PC unit and the instruction fetch path of the pipelined MIPS core.
- Each cycle it selects the next-PC source, stalls the PC, and issues IF/ID and ID/EX flushes.
- Inputs it arbitrates: instruction-memory handshake, load-use hazards, and control-flow redirects resolved in ID/EX.
- Keeps saturating counters of redirects and stall cycles for performance inspection.

Parameters:
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (legal range 1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  ID/EX holds a valid (non-bubble) instruction.
- ctrl_flow  input  2  next-PC class of the ID/EX instruction: 00 PC+4, 01 branch, 10 jump, 11 register jump.
- branch_test  input  1  branch condition result for the ID/EX instruction.
- load_use  input  1  hazard detector: the ID instruction depends on the load currently in EX.
- imem_ack  input  1  instruction memory returns the fetch word this cycle.
- imem_req  output  1  fetch request; held high until acknowledged or cancelled.
- npc_from  output  2  source select for the next-PC unit, same encoding as ctrl_flow.
- npc_branch_test  output  1  branch_test gated by ex_valid, fed to the next-PC unit.
- pc_stall  output  1  PC holds its value this edge.
- flush_if_id  output  1  IF/ID register becomes a bubble this edge.
- flush_id_ex  output  1  ID/EX register becomes a bubble this edge.
- redirect_cnt  output  CNT_W  accepted redirects, saturating.
- stall_cnt  output  CNT_W  cycles with pc_stall=1 outside BOOT, saturating.

Behaviour:
- Outputs are combinational from registered state plus current inputs, because the next-PC unit samples them on the same edge. State, hazard counter and performance counters are registered.
- Reset (rst=1 at an edge): state=BOOT, hazard counter=0, redirect_cnt=0, stall_cnt=0.
- Reset values of the outputs follow from the BOOT row: imem_req=0, npc_from=00, pc_stall=1, both flushes=0, npc_branch_test=0.
- Reset mid-operation aborts everything. An outstanding fetch is abandoned and a late imem_ack is ignored.
- redirect = ex_valid & (ctrl_flow==10 | ctrl_flow==11 | (ctrl_flow==01 & branch_test)).
- Default output values, unless a state rule overrides them: npc_from=00, pc_stall=0, flushes=0, imem_req=0.
- BOOT: pc_stall=1, imem_req=0. Always moves to FETCH next cycle; all inputs are ignored.
- FETCH: imem_req=1. Priority, highest first:
  - (a) redirect: npc_from=ctrl_flow, pc_stall=0, flush_if_id=1, redirect_cnt++. Stay in FETCH. The pending fetch is cancelled whether or not imem_ack=1. load_use is ignored because the ID instruction is flushed.
  - (b) !imem_ack: pc_stall=1, npc_from=00. Stay in FETCH.
  - (c) load_use: pc_stall=1, flush_id_ex=1. Go to HAZARD with counter=LOAD_STALL_CYCLES-1; with LOAD_STALL_CYCLES=1 go straight back to FETCH.
  - (d) otherwise: npc_from=00, pc_stall=0. Stay in FETCH.
- HAZARD: imem_req=0, pc_stall=1, flush_id_ex=1. Counter decrements each cycle; at 0 go to FETCH.
  - A redirect arriving while in HAZARD applies rule (a) and exits to FETCH immediately, clearing the counter.
- npc_from=01 is driven only when branch_test=1. A not-taken branch drives 00.
- The stall_cnt increment condition is exactly pc_stall & state!=BOOT.
- Both counters stick at all-ones and never wrap.
- Invariant: flush_if_id and pc_stall are never 1 in the same cycle.

Test Plan:
- rst high 3 cycles, then low, imem_ack=1, no hazards -> first cycle: BOOT, pc_stall=1, imem_req=0. Then FETCH with npc_from=00, pc_stall=0 every cycle; counters stay 0.
- In FETCH, imem_ack low for 4 cycles, then high -> pc_stall=1 for exactly 4 cycles, stall_cnt=4, imem_req held high throughout.
- LOAD_STALL_CYCLES=3, load_use pulse with imem_ack=1 -> pc_stall=1 and flush_id_ex=1 for 3 consecutive cycles, then normal fetch; stall_cnt=3.
- ex_valid=1, ctrl_flow=01, branch_test=1 together with load_use=1 -> npc_from=01, flush_if_id=1, pc_stall=0, redirect_cnt=1, no HAZARD entry. The same case with branch_test=0 -> npc_from=00 and a HAZARD entry.
- In HAZARD with counter=2, inject ex_valid=1, ctrl_flow=11 -> that cycle npc_from=11, flush_if_id=1; next cycle state is FETCH.
- CNT_W=4, 20 consecutive jumps -> redirect_cnt saturates at 15. Assert rst mid-stream -> all counters 0 and state BOOT on the next edge.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// Next-PC / fetch sequencing controller: picks the next-PC source, stalls the PC,
// issues IF/ID and ID/EX flushes, and keeps saturating redirect/stall counters.
module pc_flow_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [1:0]       ctrl_flow,
    input  logic             branch_test,
    input  logic             load_use,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic [1:0]       npc_from,
    output logic             npc_branch_test,
    output logic             pc_stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HAZARD = 2'd2
    } state_t;

    localparam logic [2:0] HZ_LOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] hz_cnt, hz_cnt_nxt;
    logic       redirect;
    logic       redirect_acc;

    assign redirect = ex_valid & ((ctrl_flow == 2'b10) | (ctrl_flow == 2'b11) |
                                  ((ctrl_flow == 2'b01) & branch_test));

    // NOTE: every output of this block is given a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt       = state;
        hz_cnt_nxt      = hz_cnt;
        imem_req        = 1'b0;
        npc_from        = 2'b00;
        npc_branch_test = 1'b0;
        pc_stall        = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        redirect_acc    = 1'b0;
        case (state)
            BOOT: begin
                pc_stall  = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req        = 1'b1;
                npc_branch_test = ex_valid & branch_test;
                if (redirect) begin
                    // Redirect cancels the pending fetch and overrides any load-use stall.
                    npc_from     = ctrl_flow;
                    flush_if_id  = 1'b1;
                    redirect_acc = 1'b1;
                end else if (!imem_ack) begin
                    pc_stall = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    flush_id_ex = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt  = HAZARD;
                        hz_cnt_nxt = HZ_LOAD;
                    end
                end
            end
            HAZARD: begin
                npc_branch_test = ex_valid & branch_test;
                if (redirect) begin
                    npc_from     = ctrl_flow;
                    flush_if_id  = 1'b1;
                    redirect_acc = 1'b1;
                    state_nxt    = FETCH;
                    hz_cnt_nxt   = 3'd0;
                end else begin
                    pc_stall    = 1'b1;
                    flush_id_ex = 1'b1;
                    if (hz_cnt <= 3'd1) begin
                        state_nxt  = FETCH;
                        hz_cnt_nxt = 3'd0;
                    end else begin
                        hz_cnt_nxt = hz_cnt - 3'd1;
                    end
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BOOT;
            hz_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            hz_cnt <= hz_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redirect_acc && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + 1'b1;
            if (pc_stall && (state != BOOT) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: hand-written vector table plus random traffic checked
// against a bubble-counting reference model, on a 3-bubble and a 1-bubble instance.
module tb_pc_flow_ctrl;

    typedef struct {
        bit boot;
        int bubbles;
        int redirects;
        int stalls;
    } mdl_t;

    typedef struct {
        bit       req;
        bit [1:0] npc;
        bit       nbt;
        bit       stall;
        bit       fif;
        bit       fex;
    } out_t;

    typedef struct {
        bit       rst;
        bit       ev;
        bit [1:0] cf;
        bit       bt;
        bit       lu;
        bit       ack;
        bit       chk;
        out_t     exp;
        int       rc;
        int       sc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex_valid = 1'b0;
    logic [1:0] ctrl_flow = 2'b00;
    logic       branch_test = 1'b0;
    logic       load_use = 1'b0;
    logic       imem_ack = 1'b0;

    logic        req3, nbt3, stall3, fif3, fex3;
    logic [1:0]  npc3;
    logic [3:0]  rc3, sc3;
    logic        req1, nbt1, stall1, fif1, fex1;
    logic [1:0]  npc1;
    logic [15:0] rc1, sc1;

    int total = 0;
    int bad   = 0;

    mdl_t m3, m1;
    bit   known = 1'b0;

    always #5 clk = ~clk;

    pc_flow_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ctrl_flow(ctrl_flow),
        .branch_test(branch_test), .load_use(load_use), .imem_ack(imem_ack),
        .imem_req(req3), .npc_from(npc3), .npc_branch_test(nbt3), .pc_stall(stall3),
        .flush_if_id(fif3), .flush_id_ex(fex3), .redirect_cnt(rc3), .stall_cnt(sc3)
    );

    pc_flow_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ctrl_flow(ctrl_flow),
        .branch_test(branch_test), .load_use(load_use), .imem_ack(imem_ack),
        .imem_req(req1), .npc_from(npc1), .npc_branch_test(nbt1), .pc_stall(stall1),
        .flush_if_id(fif1), .flush_id_ex(fex1), .redirect_cnt(rc1), .stall_cnt(sc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_redirect(bit ev, bit [1:0] cf, bit bt);
        return ev && (cf == 2'd2 || cf == 2'd3 || (cf == 2'd1 && bt));
    endfunction

    // Outputs follow from where the pipeline stands: booting, bubbles still owed, or fetching.
    function automatic out_t model_out(mdl_t m, bit ev, bit [1:0] cf, bit bt, bit lu, bit ack);
        out_t o;
        o = '{default: 0};
        if (m.boot) begin
            o.stall = 1;
        end else begin
            o.nbt = ev & bt;
            if (is_redirect(ev, cf, bt)) begin
                o.npc = cf;
                o.fif = 1;
                o.req = (m.bubbles == 0);
            end else if (m.bubbles > 0) begin
                o.stall = 1;
                o.fex   = 1;
            end else begin
                o.req = 1;
                if (!ack) o.stall = 1;
                else if (lu) begin
                    o.stall = 1;
                    o.fex   = 1;
                end
            end
        end
        return o;
    endfunction

    function automatic mdl_t model_next(mdl_t m, int bubbles_per_load, int max_cnt,
                                        bit r, bit ev, bit [1:0] cf, bit bt, bit lu, bit ack);
        mdl_t n;
        out_t o;
        if (r) return '{boot: 1, bubbles: 0, redirects: 0, stalls: 0};
        o = model_out(m, ev, cf, bt, lu, ack);
        n = m;
        n.boot = 0;
        if (!m.boot) begin
            if (is_redirect(ev, cf, bt)) begin
                n.bubbles   = 0;
                n.redirects = (m.redirects < max_cnt) ? m.redirects + 1 : max_cnt;
            end else if (m.bubbles > 0) begin
                n.bubbles = m.bubbles - 1;
            end else if (ack && lu) begin
                n.bubbles = bubbles_per_load - 1;
            end
            if (o.stall) n.stalls = (m.stalls < max_cnt) ? m.stalls + 1 : max_cnt;
        end
        return n;
    endfunction

    task automatic cmp_dut(input string tag, input out_t e, input int rc, input int sc,
                           input logic req, input logic [1:0] npc, input logic nbt,
                           input logic stall, input logic fif, input logic fex,
                           input logic [31:0] rc_act, input logic [31:0] sc_act);
        check({tag, ".imem_req"}, 32'(req), 32'(e.req));
        check({tag, ".npc_from"}, 32'(npc), 32'(e.npc));
        check({tag, ".npc_branch_test"}, 32'(nbt), 32'(e.nbt));
        check({tag, ".pc_stall"}, 32'(stall), 32'(e.stall));
        check({tag, ".flush_if_id"}, 32'(fif), 32'(e.fif));
        check({tag, ".flush_id_ex"}, 32'(fex), 32'(e.fex));
        check({tag, ".redirect_cnt"}, rc_act, 32'(rc));
        check({tag, ".stall_cnt"}, sc_act, 32'(sc));
    endtask

    task automatic apply(input bit r, input bit ev, input bit [1:0] cf, input bit bt,
                         input bit lu, input bit ack);
        @(negedge clk);
        rst         = r;
        ex_valid    = ev;
        ctrl_flow   = cf;
        branch_test = bt;
        load_use    = lu;
        imem_ack    = ack;
        #1;
        if (known) begin
            cmp_dut("model3", model_out(m3, ev, cf, bt, lu, ack), m3.redirects, m3.stalls,
                    req3, npc3, nbt3, stall3, fif3, fex3, 32'(rc3), 32'(sc3));
            cmp_dut("model1", model_out(m1, ev, cf, bt, lu, ack), m1.redirects, m1.stalls,
                    req1, npc1, nbt1, stall1, fif1, fex1, 32'(rc1), 32'(sc1));
        end
    endtask

    task automatic advance();
        m3 = model_next(m3, 3, 15, rst, ex_valid, ctrl_flow, branch_test, load_use, imem_ack);
        m1 = model_next(m1, 1, 65535, rst, ex_valid, ctrl_flow, branch_test, load_use, imem_ack);
        @(posedge clk);
        if (rst) known = 1'b1;
    endtask

    function automatic vec_t mk(bit r, bit ev, bit [1:0] cf, bit bt, bit lu, bit ack, bit chk,
                                bit req, bit [1:0] npc, bit nbt, bit stall, bit fif, bit fex,
                                int rc, int sc);
        vec_t v;
        v.rst = r; v.ev = ev; v.cf = cf; v.bt = bt; v.lu = lu; v.ack = ack; v.chk = chk;
        v.exp = '{req: req, npc: npc, nbt: nbt, stall: stall, fif: fif, fex: fex};
        v.rc = rc; v.sc = sc;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        // Expected values below are for the 3-bubble, 4-bit-counter instance.
        tbl[0]  = mk(1,0,2'd0,0,0,0, 0, 0,2'd0,0,0,0,0, 0,0);
        tbl[1]  = mk(1,0,2'd0,0,0,0, 1, 0,2'd0,0,1,0,0, 0,0);
        tbl[2]  = mk(1,0,2'd0,0,0,0, 1, 0,2'd0,0,1,0,0, 0,0);
        tbl[3]  = mk(0,0,2'd0,0,0,1, 1, 0,2'd0,0,1,0,0, 0,0);
        tbl[4]  = mk(0,0,2'd0,0,0,1, 1, 1,2'd0,0,0,0,0, 0,0);
        tbl[5]  = mk(0,0,2'd0,0,0,1, 1, 1,2'd0,0,0,0,0, 0,0);
        tbl[6]  = mk(0,0,2'd0,0,0,0, 1, 1,2'd0,0,1,0,0, 0,0);
        tbl[7]  = mk(0,0,2'd0,0,0,0, 1, 1,2'd0,0,1,0,0, 0,1);
        tbl[8]  = mk(0,0,2'd0,0,0,0, 1, 1,2'd0,0,1,0,0, 0,2);
        tbl[9]  = mk(0,0,2'd0,0,0,0, 1, 1,2'd0,0,1,0,0, 0,3);
        tbl[10] = mk(0,0,2'd0,0,0,1, 1, 1,2'd0,0,0,0,0, 0,4);
        tbl[11] = mk(0,0,2'd0,0,1,1, 1, 1,2'd0,0,1,0,1, 0,4);
        tbl[12] = mk(0,0,2'd0,0,0,1, 1, 0,2'd0,0,1,0,1, 0,5);
        tbl[13] = mk(0,0,2'd0,0,0,1, 1, 0,2'd0,0,1,0,1, 0,6);
        tbl[14] = mk(0,0,2'd0,0,0,1, 1, 1,2'd0,0,0,0,0, 0,7);
        tbl[15] = mk(0,1,2'd1,1,1,1, 1, 1,2'd1,1,0,1,0, 0,7);
        tbl[16] = mk(0,1,2'd1,0,1,1, 1, 1,2'd0,0,1,0,1, 1,7);
        tbl[17] = mk(0,1,2'd3,0,0,1, 1, 0,2'd3,0,0,1,0, 1,8);
        tbl[18] = mk(0,0,2'd0,0,0,1, 1, 1,2'd0,0,0,0,0, 2,8);
        tbl[19] = mk(0,0,2'd2,1,0,1, 1, 1,2'd0,0,0,0,0, 2,8);

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].rst, tbl[i].ev, tbl[i].cf, tbl[i].bt, tbl[i].lu, tbl[i].ack);
            if (tbl[i].chk)
                cmp_dut($sformatf("vec%0d", i), tbl[i].exp, tbl[i].rc, tbl[i].sc,
                        req3, npc3, nbt3, stall3, fif3, fex3, 32'(rc3), 32'(sc3));
            advance();
        end

        // Back-to-back jumps drive the 4-bit redirect counter into saturation.
        for (int i = 0; i < 20; i++) begin
            apply(0, 1, 2'd2, 0, 0, 1);
            check("jump_flush", 32'(fif3), 32'd1);
            advance();
        end
        apply(1, 1, 2'd2, 0, 0, 1);
        check("redirect_sat", 32'(rc3), 32'd15);
        advance();
        // Back in BOOT after a mid-stream reset; a stray ack must not matter.
        apply(0, 0, 2'd0, 0, 0, 1);
        check("rst_boot_stall", 32'(stall3), 32'd1);
        check("rst_boot_req", 32'(req3), 32'd0);
        check("rst_redirect_cnt", 32'(rc3), 32'd0);
        check("rst_stall_cnt", 32'(sc3), 32'd0);
        advance();

        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(99) == 0), $urandom_range(1), 2'($urandom_range(3)),
                  $urandom_range(1), ($urandom_range(3) == 0), ($urandom_range(3) != 0));
            check("no_stall_on_flush", 32'(fif3 & stall3) | 32'(fif1 & stall1), 32'd0);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
